// File: rtl/rw_transfer_unit.sv
// Block-copy datapath fed by the Read/Write strobe sequencer.
// Read captures a source word, Write commits it to the destination.
module rw_transfer_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] src_data,
    input  logic              dst_ready,
    output logic [ADDR_W-1:0] src_addr,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              Slowrun,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [DATA_W-1:0] hold;
    logic [ADDR_W:0]   remaining;
    logic              hold_valid;

    logic act;
    logic rd_ok;
    logic wr_ok;
    logic underrun;
    logic collide;
    logic accept;

    // Classify the strobes seen this cycle; only ACTIVE reacts to them.
    always_comb begin
        act      = (state == ACTIVE);
        accept   = (state == IDLE) && start;
        rd_ok    = act && Read && !Write;
        wr_ok    = act && Write && !Read && hold_valid;
        underrun = act && Write && !Read && !hold_valid;
        collide  = act && Read && Write;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: empty blocks go straight to DONE; last write ends a block.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (wr_ok && remaining == CNT_ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointers, holding register, counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr    <= '0;
            dst_ptr    <= '0;
            hold       <= '0;
            count      <= '0;
            remaining  <= '0;
            hold_valid <= 1'b0;
            err        <= 1'b0;
        end else if (accept) begin
            src_ptr    <= src_base;
            dst_ptr    <= dst_base;
            remaining  <= len;
            count      <= '0;
            hold_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (rd_ok) begin
                hold       <= src_data;
                hold_valid <= 1'b1;
                src_ptr    <= src_ptr + PTR_ONE;
                if (hold_valid) begin
                    err <= 1'b1;
                end
            end
            if (wr_ok) begin
                dst_ptr    <= dst_ptr + PTR_ONE;
                count      <= count + CNT_ONE;
                remaining  <= remaining - CNT_ONE;
                hold_valid <= 1'b0;
            end
            if (underrun || collide) begin
                err <= 1'b1;
            end
        end
    end

    // Outputs; the write enable is masked by reset so a mid-block reset
    // can never leak a store.
    always_comb begin
        src_addr = src_ptr;
        dst_addr = dst_ptr;
        dst_data = hold;
        dst_we   = wr_ok && !rst;
        Slowrun  = act && !dst_ready;
        busy     = act;
        done     = (state == DONE);
    end

endmodule
